// File: rtl/cache_backing_memory_pkg.sv
// Shared types and derivation helpers for the cache backing memory.
// The state encoding is exported so checkers can bind to the FSM directly.
package cache_backing_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RBURST = 2'd2,
    ST_WBURST = 2'd3
  } state_t;

  localparam int WORD_BYTES = 4;

  // Counter widths must stay >= 1 even when the count range degenerates to one value.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/cache_backing_memory_if.sv
// Miss-side bus between the cache controller (master) and the backing memory (slave).
interface cache_backing_memory_if;
  // Handshake: the master raises mem_read or mem_write with mem_address and holds it until it
  // samples mem_last; the slave accepts only while idle, stays mem_busywait until the burst ends,
  // strobes mem_rvalid (read data valid) or mem_wready (write data taken at that edge) once per
  // beat, and marks the final beat with mem_last. The request must drop at the edge after mem_last
  // unless a back-to-back burst is wanted.
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_busywait;
  logic [31:0] mem_readdata;
  logic        mem_rvalid;
  logic        mem_wready;
  logic        mem_last;
  logic        mem_proto_err;

  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_busywait, mem_readdata, mem_rvalid, mem_wready, mem_last, mem_proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_busywait, mem_readdata, mem_rvalid, mem_wready, mem_last, mem_proto_err
  );
endinterface

// File: rtl/cache_backing_memory_mem_word_array.sv
// Single-port synchronous word RAM: one read or write per cycle, registered read data.
// Contents are deliberately not reset so they survive a controller reset.
module mem_word_array #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_backing_memory.sv
// Block-burst main-memory responder: fixed access latency, then one 32-bit word per cycle
// for refills (read bursts) and write-backs (write bursts).
module cache_backing_memory
  import cache_backing_memory_pkg::*;
#(
  parameter int BLOCK_SIZE  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  cache_backing_memory_if.slave        bus,
  output state_t                       state_dbg
);

  localparam int BLOCK_WORDS = BLOCK_SIZE / WORD_BYTES;
  localparam int OFFSET_W    = $clog2(BLOCK_SIZE);
  localparam int BEAT_W      = clog2_min1(BLOCK_WORDS);
  localparam int ADDR_W      = $clog2(DEPTH_WORDS);
  localparam int BLOCK_W     = ADDR_W - BEAT_W;
  localparam int LAT_W       = clog2_min1(LATENCY);

  state_t              state;
  state_t              state_next;
  logic [BLOCK_W-1:0]  block_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [LAT_W-1:0]    lat_q;
  logic                is_write_q;
  logic                proto_err_q;
  logic                req;
  logic                lat_done;
  logic                beat_done;
  logic                ram_we;
  logic [BEAT_W-1:0]   ram_beat;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_rdata;
  logic                unused_addr_bits;

  assign req       = bus.mem_read | bus.mem_write;
  assign lat_done  = (lat_q == LAT_W'(LATENCY - 1));
  assign beat_done = (beat_q == BEAT_W'(BLOCK_WORDS - 1));
  assign state_dbg = state;

  // Offset bits and address bits above the array size are intentionally discarded.
  assign unused_addr_bits = ^{bus.mem_address[31:OFFSET_W+BLOCK_W], bus.mem_address[OFFSET_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req) state_next = ST_WAIT;
      ST_WAIT:   if (lat_done) state_next = is_write_q ? ST_WBURST : ST_RBURST;
      ST_RBURST: if (beat_done) state_next = ST_IDLE;
      ST_WBURST: if (beat_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q     <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      is_write_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            block_q     <= bus.mem_address[OFFSET_W +: BLOCK_W];
            is_write_q  <= bus.mem_write;
            proto_err_q <= bus.mem_read & bus.mem_write;
            lat_q       <= '0;
            beat_q      <= '0;
          end
        end
        ST_WAIT:   lat_q  <= lat_q + LAT_W'(1);
        ST_RBURST: beat_q <= beat_q + BEAT_W'(1);
        ST_WBURST: beat_q <= beat_q + BEAT_W'(1);
        default:   beat_q <= '0;
      endcase
    end
  end

  // The RAM read runs one beat ahead so its registered output lines up with the current beat;
  // during the last wait cycle (beat_q is 0) it fetches beat 0.
  always_comb begin
    ram_we   = (state == ST_WBURST);
    ram_beat = '0;
    if (state == ST_RBURST) begin
      ram_beat = beat_q + BEAT_W'(1);
    end else if (state == ST_WBURST) begin
      ram_beat = beat_q;
    end
    ram_addr = {block_q, ram_beat};
  end

  always_comb begin
    bus.mem_busywait  = (state != ST_IDLE) | req;
    bus.mem_rvalid    = (state == ST_RBURST);
    bus.mem_wready    = (state == ST_WBURST);
    bus.mem_last      = ((state == ST_RBURST) | (state == ST_WBURST)) & beat_done;
    bus.mem_readdata  = (state == ST_RBURST) ? ram_rdata : 32'h0;
    bus.mem_proto_err = proto_err_q;
  end

  mem_word_array #(
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (bus.mem_writedata),
    .rdata (ram_rdata)
  );

endmodule
